// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: CPU request/response handshake plus the
// word-wide data memory port. master = the LSU, slave = CPU/memory side.
interface load_store_unit_if #(
  parameter int unsigned MEM_AW = 13
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              MemRead;
  logic              MemWrite;
  logic [MEM_AW-1:0] Address;
  logic [31:0]       Write_data;
  logic [31:0]       Read_Data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           Read_Data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           MemRead, MemWrite, Address, Write_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           Read_Data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           MemRead, MemWrite, Address, Write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word MemRead/MemWrite
// accesses, with read-modify-write for sub-word stores. Optional macro
// LSU_ALIGN_CHECK_EN makes misaligned half/word accesses an error.
module load_store_unit #(
  parameter int unsigned MEM_AW = 13
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  a_off;
  logic [1:0]  a_size;
  logic        a_signed;
  logic        a_write;
  logic [15:0] a_wdata;

  logic size_bad, range_bad, misalign, req_bad;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        2'd3: r[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction

  always_comb begin
    size_bad  = (bus.req_size == 2'b11);
    range_bad = ((bus.req_addr >> (MEM_AW + 2)) != '0);
`ifdef LSU_ALIGN_CHECK_EN
    misalign  = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    req_bad   = size_bad || range_bad || misalign;
  end

  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      a_off           <= '0;
      a_size          <= '0;
      a_signed        <= 1'b0;
      a_write         <= 1'b0;
      a_wdata         <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.MemRead     <= 1'b0;
      bus.MemWrite    <= 1'b0;
      bus.Address     <= '0;
      bus.Write_data  <= '0;
    end else begin
      bus.MemRead    <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_size   <= bus.req_size;
            a_signed <= bus.req_signed;
            a_write  <= bus.req_write;
            a_wdata  <= bus.req_wdata[15:0];
            // Without the alignment check, halfword/word lanes are forced aligned.
            case (bus.req_size)
              2'b01:   a_off <= {bus.req_addr[1], 1'b0};
              2'b10:   a_off <= 2'b00;
              default: a_off <= bus.req_addr[1:0];
            endcase
            if (req_bad) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              state          <= ERR;
            end else begin
              bus.Address <= bus.req_addr[MEM_AW+1:2];
              if (bus.req_write && (bus.req_size == 2'b10)) begin
                bus.Write_data <= bus.req_wdata;
                bus.MemWrite   <= 1'b1;
                state          <= WRITE;
              end else begin
                bus.MemRead <= 1'b1;
                state       <= READ;
              end
            end
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          if (a_write) begin
            bus.Write_data <= store_merge(bus.Read_Data, a_wdata, a_off, a_size);
            bus.MemWrite   <= 1'b1;
            state          <= WRITE;
          end else begin
            bus.resp_rdata <= load_extract(bus.Read_Data, a_off, a_size, a_signed);
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end
        end
        WRITE: begin
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan steps followed by
// random traffic, checked against a word-array reference model.
module tb_load_store_unit;
  localparam int unsigned MEM_AW = 13;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] seed;

  load_store_unit_if #(.MEM_AW(MEM_AW)) bus ();
  load_store_unit #(.MEM_AW(MEM_AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          mem_init_done = 1'b0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E3779B9) ^ seed;
  endfunction

  // Data memory: registered read on MemRead, write on negedge while MemWrite.
  always @(posedge clock) if (bus.MemRead === 1'b1) bus.Read_Data <= mem[bus.Address];
  always @(negedge clock) begin
    if (!mem_init_done) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] = init_word(i);
      mem_init_done = 1'b1;
    end
    if (bus.MemWrite === 1'b1) mem[bus.Address] = bus.Write_data;
  end

  // Bus-protocol monitor for MemRead shape and MemRead/MemWrite exclusion.
  int unsigned proto_viol = 0;
  int unsigned low_run    = 0;
  bit          seen_read  = 1'b0;
  bit          mr_prev    = 1'b0;
  always @(negedge clock) begin
    if (bus.MemRead === 1'b1) begin
      if (mr_prev) proto_viol++;
      else if (seen_read && low_run < 2) proto_viol++;
      seen_read = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    if (bus.MemRead === 1'b1 && bus.MemWrite === 1'b1) proto_viol++;
    mr_prev = (bus.MemRead === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input int unsigned sz, input int unsigned a);
    bit e;
    e = (sz == 3) || (a >= (4 << MEM_AW));
`ifdef LSU_ALIGN_CHECK_EN
    if (sz == 1 && (a % 2) != 0) e = 1'b1;
    if (sz == 2 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int unsigned lane_off(input int unsigned sz, input int unsigned a);
    int unsigned off;
    off = a % 4;
    if (sz == 1) off = off - (off % 2);
    if (sz == 2) off = 0;
    return off;
  endfunction

  function automatic logic [31:0] model_load(input int unsigned sz, input bit sg, input int unsigned a);
    int unsigned word, off, v;
    word = ref_mem[(a / 4) % DEPTH];
    off  = lane_off(sz, a);
    if (sz == 0) begin
      v = (word >> (8 * off)) % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = (word >> (8 * off)) % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input int unsigned sz, input int unsigned a, input int unsigned wd);
    int unsigned old, off, mask;
    old  = ref_mem[(a / 4) % DEPTH];
    off  = lane_off(sz, a);
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  logic [31:0] last_rdata, last_wdata;
  logic        last_err;
  int unsigned last_lat;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned waitn, lat, nrd, nwr, idx, elat, enrd, enwr;
    logic [31:0] rdata, wdat, rdaddr, wraddr, erdata, ewdat;
    logic        err, eerr;
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    waitn = 0;
    while (bus.req_ready !== 1'b1 && waitn < 10) begin
      @(negedge clock);
      waitn++;
    end
    check("ready_wait", {31'b0, bus.req_ready}, 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_write  = 1'($urandom);
    lat = 0; nrd = 0; nwr = 0; err = 1'bx;
    rdata = 'x; wdat = 'x; rdaddr = 'x; wraddr = 'x;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1;
      end
      if (bus.MemRead === 1'b1) begin nrd++; rdaddr = 32'(bus.Address); end
      if (bus.MemWrite === 1'b1) begin nwr++; wraddr = 32'(bus.Address); wdat = bus.Write_data; end
      if (bus.resp_valid === 1'b1) begin
        lat = c; err = bus.resp_err; rdata = bus.resp_rdata;
      end
    end
    idx  = (a / 4) % DEPTH;
    eerr = model_err(sz, a);
    erdata = 32'd0;
    ewdat  = 32'd0;
    if (eerr) begin
      elat = 1; enrd = 0; enwr = 0;
    end else if (!w) begin
      elat = 3; enrd = 1; enwr = 0; erdata = model_load(sz, sg, a);
    end else if (sz == 2'b10) begin
      elat = 2; enrd = 0; enwr = 1; ewdat = wd;
    end else begin
      elat = 4; enrd = 1; enwr = 1; ewdat = model_store(sz, a, wd);
    end
    check("latency",  lat, elat);
    check("resp_err", {31'b0, err}, {31'b0, eerr});
    check("rdata",    rdata, erdata);
    check("n_reads",  nrd, enrd);
    check("n_writes", nwr, enwr);
    if (enrd != 0) check("read_addr", rdaddr, idx);
    if (enwr != 0) begin
      check("write_addr", wraddr, idx);
      check("write_data", wdat, ewdat);
      ref_mem[idx] = ewdat;
    end
    last_rdata = rdata;
    last_wdata = wdat;
    last_err   = err;
    last_lat   = lat;
  endtask

  initial begin
    int unsigned r, nz;
    logic [1:0]  sz;
    seed = $urandom;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready",  {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_memread",    {31'b0, bus.MemRead}, 32'd0);
    check("rst_memwrite",   {31'b0, bus.MemWrite}, 32'd0);
    check("rst_address",    32'(bus.Address), 32'd0);
    check("rst_write_data", bus.Write_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("tp1_wr_data", last_wdata, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("tp1_rdata", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA);
    check("tp2_merge", last_wdata, 32'h11AA3344);
    do_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
    check("tp2_rdata", last_rdata, 32'h000000AA);

    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80017F80);
    do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    check("tp3_hs", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("tp3_hu", last_rdata, 32'h00008001);
    do_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
    check("tp3_bs", last_rdata, 32'hFFFFFF80);

    do_req(1'b0, 2'b10, 1'b0, 32'h00008000, 32'h0);
    check("tp4_err", {31'b0, last_err}, 32'd1);
    check("tp4_lat", last_lat, 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    check("size11_err", {31'b0, last_err}, 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("tp5_err", {31'b0, last_err}, 32'd1);
`else
    check("tp5_rdata", last_rdata, 32'hCAFEF00D);
`endif

    // Reset while a byte store sits in READ: nothing must reach memory.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h41; bus.req_wdata = 32'h99;
    nz = 0;
    while (bus.req_ready !== 1'b1 && nz < 10) begin @(negedge clock); nz++; end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    check("abort_in_read", {31'b0, bus.MemRead}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_ready",    {31'b0, bus.req_ready}, 32'd1);
    check("abort_memread",  {31'b0, bus.MemRead}, 32'd0);
    check("abort_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    check("abort_valid",    {31'b0, bus.resp_valid}, 32'd0);
    check("abort_address",  32'(bus.Address), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    nz = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.resp_valid !== 1'b0 || bus.MemWrite !== 1'b0) nz++;
    end
    check("abort_quiet", nz, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("abort_mem_intact", last_rdata, 32'h55667788);

    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);

    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 19);
      sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             (r == 1) ? ($urandom | 32'h8000) : (32'h100 + $urandom_range(0, 63)),
             $urandom);
    end

    check("memread_protocol", proto_viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface. Converts CPU load/store requests (byte, halfword, word; signed or unsigned) into MemRead/MemWrite word accesses on the data memory.
- Performs read-modify-write for sub-word stores.
- Extracts and sign- or zero-extends sub-word loads.
- Sits between the execute stage and the data memory; stalls the CPU via req_ready.

Parameters:
- MEM_AW, 13, data memory word-address width; memory holds 2^MEM_AW 32-bit words.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and gives an error.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/half taken from low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid; 1 = request rejected, no memory access made.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- MemRead  output  1  to data memory; the memory samples on its rising edge.
- MemWrite  output  1  to data memory; the memory writes on the negedge of the cycle it is high.
- Address  output  MEM_AW  word address = req_addr[MEM_AW+1:2].
- Write_data  output  32  word to write.
- Read_Data  input  32  word from memory; valid the cycle after MemRead rises.

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, MemRead 0, MemWrite 0, Address 0, Write_data 0. All outputs are registered except req_ready, which is decoded from state.
- Acceptance: a request is accepted on a posedge with req_valid && req_ready. The unit latches addr, size, signed, write and wdata at acceptance.
- Byte lanes are little-endian:
  - offset = addr[1:0]; byte k occupies bits 8k+7:8k.
  - halfword at offset 0 uses bits 15:0; offset 2 uses bits 31:16.
- Error check at acceptance, goes to ERR if any of:
  - size==11;
  - addr[31:MEM_AW+2] != 0 (out of range);
  - misaligned (see Optional Feature).
- States:
  - IDLE: on accept, go to ERR if error; else WRITE if store word; else READ.
  - READ: MemRead=1, Address driven. Next state LATCH.
  - LATCH: MemRead=0; capture Read_Data.
    - Load: extract lane, extend, store in resp_rdata, go to DONE.
    - Sub-word store: merge the wdata lane into the captured word to form Write_data, go to WRITE.
  - WRITE: MemWrite=1, Address and Write_data stable for the whole cycle. Next state DONE.
  - DONE: MemWrite=0, resp_valid=1, resp_err=0. Next state IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Next state IDLE. No MemRead/MemWrite pulse.
- Latency from the acceptance edge to the resp_valid cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- Next acceptance is possible one cycle after resp_valid (IDLE).
- MemRead invariants:
  - high exactly one cycle per read;
  - always low for at least 2 cycles between reads, so every read produces a fresh rising edge;
  - never high together with MemWrite.
- Back-to-back requests: req_valid held high across DONE is not accepted until IDLE. No request is dropped or duplicated.
- Reset mid-operation: the next posedge returns to IDLE with all outputs at reset values, and no resp_valid is produced for the aborted request. A store aborted in WRITE still commits, because MemWrite was already high into that cycle's negedge. A store aborted before WRITE leaves memory untouched.
- Address and Write_data hold their last values in IDLE; only MemRead/MemWrite qualify them.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is an error and goes to ERR.
- Undefined: no alignment error.
  - Halfword forces addr[0]=0 and word forces addr[1:0]=0 before lane selection.
  - The access proceeds normally.
  - size==11 and out-of-range errors remain in both builds.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10, then load word at 0x10 -> MemWrite one cycle at Address 4. The load returns resp_rdata 0xDEADBEEF 3 cycles after acceptance, resp_err 0.
- With word 0x11223344 at addr 0x20: store byte 0xAA at 0x22 -> a READ then a WRITE cycle with Write_data 0x11AA3344. A load byte unsigned at 0x22 then returns 0x000000AA.
- With word 0x8001_7F80 at addr 0x30:
  - load half signed at 0x32 -> 0xFFFF8001;
  - load half unsigned at 0x32 -> 0x00008001;
  - load byte signed at 0x30 -> 0xFFFFFF80.
- req_addr 0x00008000 (MEM_AW=13) -> resp_valid with resp_err 1 one cycle after accept; MemRead and MemWrite stay 0; resp_rdata 0.
- Load word at 0x6:
  - with LSU_ALIGN_CHECK_EN, resp_err 1 with no memory access;
  - without it, the unit reads Address 1 and returns that word.
- Assert reset during READ of a byte store -> next cycle state is IDLE, MemRead 0, no MemWrite pulse, no resp_valid, and the memory word is unchanged. Two back-to-back loads show MemRead low for at least 2 cycles between pulses.
